// File: rtl/scoreboard_ctrl_if.sv
// Issue-side bundle between the issue queue head and the scoreboard.
// Sources and destinations per lane, issue count and bypass selects back.
interface scoreboard_ctrl_if #(
  parameter int REG_ADDR_W = 5
);
  logic [1:0]                  head_valid;
  logic                        issue_ready;
  logic [3:0][REG_ADDR_W-1:0]  src_addr;
  logic [3:0]                  src_used;
  logic [1:0][REG_ADDR_W-1:0]  dst_addr;
  logic [1:0]                  dst_wen;
  logic [1:0]                  dst_is_load;
  logic [1:0]                  issue_count;
  logic [3:0][1:0]             byp_stage;
  logic [3:0]                  byp_lane;

  modport master (
    output head_valid,
    output issue_ready,
    output src_addr,
    output src_used,
    output dst_addr,
    output dst_wen,
    output dst_is_load,
    input  issue_count,
    input  byp_stage,
    input  byp_lane
  );

  modport slave (
    input  head_valid,
    input  issue_ready,
    input  src_addr,
    input  src_used,
    input  dst_addr,
    input  dst_wen,
    input  dst_is_load,
    output issue_count,
    output byp_stage,
    output byp_lane
  );
endinterface

// File: rtl/scoreboard_ctrl.sv
// Dual-issue scoreboard: tracks youngest producer per register,
// decides issue count and drives operand bypass selects.
module scoreboard_ctrl #(
  parameter int NUM_REGS    = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scoreboard_ctrl_if.slave       sb,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_NONE = 2'd0,
    ST_EX   = 2'd1,
    ST_MEM  = 2'd2,
    ST_CMT  = 2'd3
  } stage_e;

  stage_e stage_q [NUM_REGS];
  logic   lane_q  [NUM_REGS];
  logic   load_q  [NUM_REGS];

  logic [3:0] live;
  logic [3:0] hazard;
  logic       raw;
  logic       issue0;
  logic       issue1;
  logic       wr0;
  logic       wr1;
  logic       stall;

  function automatic stage_e advance(input stage_e s);
    stage_e n;
    unique case (s)
      ST_EX:   n = ST_MEM;
      ST_MEM:  n = ST_CMT;
      default: n = ST_NONE;
    endcase
    return n;
  endfunction

  always_comb begin
    live   = '0;
    hazard = '0;
    for (int p = 0; p < 4; p++) begin
      live[p] = sb.src_used[p] && (sb.src_addr[p] != '0);
      // only an EX-stage load has no result to forward yet
      hazard[p] = live[p]
        && (stage_q[sb.src_addr[p]] == ST_EX)
        && load_q[sb.src_addr[p]];
    end
  end

  always_comb begin
    raw = 1'b0;
    if (sb.dst_wen[0] && (sb.dst_addr[0] != '0)) begin
      raw = (sb.src_used[2] && (sb.src_addr[2] == sb.dst_addr[0]))
         || (sb.src_used[3] && (sb.src_addr[3] == sb.dst_addr[0]));
    end
  end

  assign issue0 = rst_n && sb.head_valid[0] && sb.issue_ready
               && !(|hazard[1:0]);
  assign issue1 = issue0 && sb.head_valid[1]
               && !(|hazard[3:2]) && !raw;

  assign sb.issue_count = {issue1, issue0 && !issue1};

  assign wr0 = issue0 && sb.dst_wen[0] && (sb.dst_addr[0] != '0);
  assign wr1 = issue1 && sb.dst_wen[1] && (sb.dst_addr[1] != '0);

  assign stall = sb.head_valid[0] && sb.issue_ready && !issue0;

  always_comb begin
    sb.byp_stage = '0;
    sb.byp_lane  = '0;
    for (int p = 0; p < 4; p++) begin
      if (rst_n && live[p]
          && (stage_q[sb.src_addr[p]] != ST_NONE)) begin
        sb.byp_stage[p] = stage_q[sb.src_addr[p]];
        sb.byp_lane[p]  = lane_q[sb.src_addr[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        stage_q[i] <= ST_NONE;
        lane_q[i]  <= 1'b0;
        load_q[i]  <= 1'b0;
      end
      stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        stage_q[i] <= advance(stage_q[i]);
        if (stage_q[i] == ST_CMT) begin
          lane_q[i] <= 1'b0;
          load_q[i] <= 1'b0;
        end
      end
      // lane 1 assigned last so it wins a same-register collision
      if (wr0) begin
        stage_q[sb.dst_addr[0]] <= ST_EX;
        lane_q[sb.dst_addr[0]]  <= 1'b0;
        load_q[sb.dst_addr[0]]  <= sb.dst_is_load[0];
      end
      if (wr1) begin
        stage_q[sb.dst_addr[1]] <= ST_EX;
        lane_q[sb.dst_addr[1]]  <= 1'b1;
        load_q[sb.dst_addr[1]]  <= sb.dst_is_load[1];
      end
      if (stall && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_scoreboard_ctrl.sv
// Directed bench for scoreboard_ctrl on a 4-bit stall counter build.
// Inputs change 1ns after posedge, outputs checked 2ns later.
module tb_scoreboard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] stall_cnt;
  int         vecs = 0;
  int         errs = 0;

  scoreboard_ctrl_if #(.REG_ADDR_W(5)) sbif ();

  scoreboard_ctrl #(
    .NUM_REGS(32),
    .REG_ADDR_W(5),
    .STALL_CNT_W(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sb(sbif),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic idle();
    sbif.head_valid  = '0;
    sbif.issue_ready = 1'b0;
    sbif.src_addr    = '0;
    sbif.src_used    = '0;
    sbif.dst_addr    = '0;
    sbif.dst_wen     = '0;
    sbif.dst_is_load = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.src_addr[0] = 5'd5;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("rst_count", 32'(sbif.issue_count), 0);
    chk("rst_byp_stage", 32'(sbif.byp_stage), 0);
    chk("rst_byp_lane", 32'(sbif.byp_lane), 0);
    tick();
    tick();
    chk("rst_stall", 32'(stall_cnt), 0);

    rst_n = 1'b1;
    idle();
    sbif.head_valid  = 2'b01;
    sbif.src_addr[0] = 5'd5;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("post_rst_r5", 32'(sbif.byp_stage[0]), 0);
    chk("not_ready_count", 32'(sbif.issue_count), 0);

    // ALU chain on r3
    idle();
    sbif.head_valid  = 2'b01;
    sbif.issue_ready = 1'b1;
    sbif.dst_addr[0] = 5'd3;
    sbif.dst_wen[0]  = 1'b1;
    #2;
    chk("alu_issue", 32'(sbif.issue_count), 1);
    tick();
    idle();
    sbif.head_valid  = 2'b01;
    sbif.src_addr[0] = 5'd3;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("alu_ex", 32'(sbif.byp_stage[0]), 1);
    chk("alu_lane", 32'(sbif.byp_lane[0]), 0);
    tick();
    chk("alu_mem", 32'(sbif.byp_stage[0]), 2);
    tick();
    chk("alu_cmt", 32'(sbif.byp_stage[0]), 3);
    tick();
    chk("alu_rf", 32'(sbif.byp_stage[0]), 0);
    chk("alu_stall", 32'(stall_cnt), 0);

    // load-use on r5
    idle();
    sbif.head_valid     = 2'b01;
    sbif.issue_ready    = 1'b1;
    sbif.dst_addr[0]    = 5'd5;
    sbif.dst_wen[0]     = 1'b1;
    sbif.dst_is_load[0] = 1'b1;
    #2;
    chk("lw_issue", 32'(sbif.issue_count), 1);
    tick();
    idle();
    sbif.head_valid  = 2'b01;
    sbif.issue_ready = 1'b1;
    sbif.src_addr[0] = 5'd5;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("lu_stall_count", 32'(sbif.issue_count), 0);
    chk("lu_byp_ex", 32'(sbif.byp_stage[0]), 1);
    chk("lu_cnt_before", 32'(stall_cnt), 0);
    tick();
    chk("lu_cnt_after", 32'(stall_cnt), 1);
    chk("lu_byp_mem", 32'(sbif.byp_stage[0]), 2);
    chk("lu_issue", 32'(sbif.issue_count), 1);
    tick();

    // intra-pair RAW on r4
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.dst_addr[0] = 5'd4;
    sbif.dst_wen[0]  = 1'b1;
    sbif.src_addr[2] = 5'd4;
    sbif.src_used[2] = 1'b1;
    #2;
    chk("raw_count", 32'(sbif.issue_count), 1);
    tick();
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.src_addr[0] = 5'd4;
    sbif.src_used[0] = 1'b1;
    sbif.src_addr[2] = 5'd10;
    sbif.src_used[2] = 1'b1;
    #2;
    chk("raw_next_byp", 32'(sbif.byp_stage[0]), 1);
    chk("raw_next_lane", 32'(sbif.byp_lane[0]), 0);
    chk("raw_r10", 32'(sbif.byp_stage[2]), 0);
    chk("dual_issue", 32'(sbif.issue_count), 2);
    tick();

    // both lanes write r7, lane 1 is a load
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.dst_addr[0] = 5'd7;
    sbif.dst_addr[1] = 5'd7;
    sbif.dst_wen     = 2'b11;
    sbif.dst_is_load = 2'b10;
    #2;
    chk("samedst_count", 32'(sbif.issue_count), 2);
    tick();
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.src_addr[1] = 5'd7;
    sbif.src_addr[3] = 5'd7;
    sbif.src_used[3] = 1'b1;
    #2;
    chk("samedst_stage", 32'(sbif.byp_stage[3]), 1);
    chk("samedst_lane", 32'(sbif.byp_lane[3]), 1);
    chk("unused_port", 32'(sbif.byp_stage[1]), 0);
    chk("lane1_lu_count", 32'(sbif.issue_count), 1);
    tick();
    chk("lane1_lu_nostall", 32'(stall_cnt), 1);

    // lane 1 alone never issues
    idle();
    sbif.head_valid  = 2'b10;
    sbif.issue_ready = 1'b1;
    #2;
    chk("lane1_only", 32'(sbif.issue_count), 0);
    tick();
    chk("lane1_only_cnt", 32'(stall_cnt), 1);

    // register zero is never tracked
    idle();
    sbif.head_valid     = 2'b01;
    sbif.issue_ready    = 1'b1;
    sbif.dst_wen[0]     = 1'b1;
    sbif.dst_is_load[0] = 1'b1;
    #2;
    chk("r0_wr_issue", 32'(sbif.issue_count), 1);
    tick();
    idle();
    sbif.head_valid  = 2'b01;
    sbif.issue_ready = 1'b1;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("r0_byp", 32'(sbif.byp_stage[0]), 0);
    chk("r0_issue", 32'(sbif.issue_count), 1);
    tick();
    chk("r0_nostall", 32'(stall_cnt), 1);

    // reset mid-operation with a load in flight
    idle();
    sbif.head_valid     = 2'b01;
    sbif.issue_ready    = 1'b1;
    sbif.dst_addr[0]    = 5'd8;
    sbif.dst_wen[0]     = 1'b1;
    sbif.dst_is_load[0] = 1'b1;
    #2;
    chk("mid_lw_issue", 32'(sbif.issue_count), 1);
    tick();
    rst_n = 1'b0;
    idle();
    sbif.head_valid  = 2'b11;
    sbif.issue_ready = 1'b1;
    sbif.src_addr[0] = 5'd8;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("mid_rst_count", 32'(sbif.issue_count), 0);
    chk("mid_rst_byp", 32'(sbif.byp_stage[0]), 0);
    tick();
    rst_n = 1'b1;
    chk("mid_rst_stall", 32'(stall_cnt), 0);
    idle();
    sbif.head_valid  = 2'b01;
    sbif.src_addr[0] = 5'd8;
    sbif.src_used[0] = 1'b1;
    #2;
    chk("mid_rst_r8", 32'(sbif.byp_stage[0]), 0);

    // lw r6,(r6) repeated: stalls every other cycle
    idle();
    sbif.head_valid     = 2'b01;
    sbif.issue_ready    = 1'b1;
    sbif.src_addr[0]    = 5'd6;
    sbif.src_used[0]    = 1'b1;
    sbif.dst_addr[0]    = 5'd6;
    sbif.dst_wen[0]     = 1'b1;
    sbif.dst_is_load[0] = 1'b1;
    #2;
    chk("sat_first_issue", 32'(sbif.issue_count), 1);
    repeat (10) tick();
    chk("sat_mid_cnt", 32'(stall_cnt), 5);
    chk("sat_mid_issue", 32'(sbif.issue_count), 1);
    repeat (30) tick();
    chk("sat_cnt", 32'(stall_cnt), 15);
    repeat (2) tick();
    chk("sat_hold", 32'(stall_cnt), 15);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
